// File: rtl/voice_gate_allocator_pkg.sv
// Shared encodings for the voice gate allocator: voice states, control FSM
// states and the decision recorded during the search cycle.
package voice_gate_allocator_pkg;

  localparam int NOTE_W_DEFAULT = 7;

  typedef enum logic [1:0] {
    V_FREE      = 2'b00,
    V_HELD      = 2'b01,
    V_RETRIG    = 2'b10,
    V_RELEASING = 2'b11
  } voice_state_e;

  typedef enum logic [1:0] {
    C_IDLE   = 2'b00,
    C_SEARCH = 2'b01,
    C_APPLY  = 2'b10
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'b00,
    ACT_LOAD   = 2'b01,
    ACT_RETRIG = 2'b10,
    ACT_OFF    = 2'b11
  } act_e;

endpackage

// File: rtl/voice_gate_allocator_slot.sv
// One voice: tracks its lifecycle (free / held / retrigger gap / releasing),
// the note it holds, how long its gate has been high and a deferred note-off.
module voice_slot
  import voice_gate_allocator_pkg::*;
#(
  parameter int NOTE_W     = NOTE_W_DEFAULT,
  parameter int MIN_GATE   = 16,
  parameter int RETRIG_LOW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              running,
  input  logic              cmd_load,
  input  logic              cmd_retrig,
  input  logic              cmd_off,
  input  logic [NOTE_W-1:0] load_note,
  output voice_state_e      state,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic              active
);

  voice_state_e      state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [7:0]        age_q, age_d;
  logic [3:0]        rcnt_q, rcnt_d;
  logic              pend_q, pend_d;

  // Voice state registers, cleared to a free, silent voice on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= V_FREE;
      note_q  <= '0;
      age_q   <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      age_q   <= age_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
    end
  end

  // Allocator commands override the voice's own progression for that cycle.
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    age_d   = age_q;
    rcnt_d  = rcnt_q;
    pend_d  = pend_q;
    if (cmd_load) begin
      state_d = V_HELD;
      note_d  = load_note;
      age_d   = '0;
      pend_d  = 1'b0;
    end else if (cmd_retrig) begin
      state_d = V_RETRIG;
      note_d  = load_note;
      rcnt_d  = 4'(RETRIG_LOW - 1);
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        V_FREE: begin
        end
        V_HELD: begin
          if (age_q != 8'd255) age_d = age_q + 8'd1;
          if ((cmd_off || pend_q) && (age_q >= 8'(MIN_GATE))) begin
            state_d = V_RELEASING;
            pend_d  = 1'b0;
          end else if (cmd_off) begin
            pend_d = 1'b1;
          end
        end
        V_RETRIG: begin
          if (cmd_off) pend_d = 1'b1;
          if (rcnt_q == 4'd0) begin
            state_d = V_HELD;
            age_d   = '0;
          end else begin
            rcnt_d = rcnt_q - 4'd1;
          end
        end
        V_RELEASING: begin
          if (!running) state_d = V_FREE;
        end
      endcase
    end
  end

  assign state  = state_q;
  assign note   = note_q;
  assign gate   = (state_q == V_HELD);
  assign active = (state_q != V_FREE);

endmodule

// File: rtl/voice_gate_allocator.sv
// Note-event to voice allocator: accepts one event, searches the voices for a
// match / free / releasing / steal target, then applies the decision.
module voice_gate_allocator
  import voice_gate_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = NOTE_W_DEFAULT,
  parameter int MIN_GATE   = 16,
  parameter int RETRIG_LOW = 2
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       EventValid,
  output logic                       EventReady,
  input  logic                       EventOn,
  input  logic [NOTE_W-1:0]          EventNote,
  input  logic [NUM_VOICES-1:0]      Running,
  output logic [NUM_VOICES-1:0]      Gate,
  output logic [NUM_VOICES*NOTE_W-1:0] VoiceNote,
  output logic [NUM_VOICES-1:0]      VoiceActive,
  output logic                       Stolen
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  ctrl_state_e       ctrl_q, ctrl_d;
  logic              ready_q, ready_d;
  logic              ev_on_q, ev_on_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  act_e              act_q, act_d;
  logic [IDX_W-1:0]  tgt_q, tgt_d;
  logic              steal_q, steal_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              stolen_q, stolen_d;

  voice_state_e      slot_state [NUM_VOICES];
  logic [NOTE_W-1:0] slot_note  [NUM_VOICES];
  logic [NUM_VOICES-1:0] cmd_load, cmd_retrig, cmd_off;

  logic             accept;
  logic             has_match, has_free, has_rel;
  logic [IDX_W-1:0] match_idx, free_idx, rel_idx;

  assign accept = EventValid && ready_q;

  // Control state, captured event, registered decision and steal pointer.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ctrl_q    <= C_IDLE;
      ready_q   <= 1'b0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      act_q     <= ACT_NONE;
      tgt_q     <= '0;
      steal_q   <= 1'b0;
      ptr_q     <= '0;
      stolen_q  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      ready_q   <= ready_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      act_q     <= act_d;
      tgt_q     <= tgt_d;
      steal_q   <= steal_d;
      ptr_q     <= ptr_d;
      stolen_q  <= stolen_d;
    end
  end

  // Control sequence: accept in IDLE, decide in SEARCH, update in APPLY.
  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      C_IDLE:   if (accept) ctrl_d = C_SEARCH;
      C_SEARCH: ctrl_d = C_APPLY;
      C_APPLY:  ctrl_d = C_IDLE;
      default:  ctrl_d = C_IDLE;
    endcase
  end

  // Priority search (lowest index wins) and decision capture.
  always_comb begin
    has_match = 1'b0;
    has_free  = 1'b0;
    has_rel   = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    rel_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (((slot_state[i] == V_HELD) || (slot_state[i] == V_RETRIG)) &&
          (slot_note[i] == ev_note_q)) begin
        has_match = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (slot_state[i] == V_FREE) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (slot_state[i] == V_RELEASING) begin
        has_rel = 1'b1;
        rel_idx = IDX_W'(i);
      end
    end

    ev_on_d   = accept ? EventOn : ev_on_q;
    ev_note_d = accept ? EventNote : ev_note_q;
    act_d     = act_q;
    tgt_d     = tgt_q;
    steal_d   = steal_q;
    ptr_d     = ptr_q;

    if (ctrl_q == C_SEARCH) begin
      steal_d = 1'b0;
      act_d   = ACT_NONE;
      tgt_d   = '0;
      if (ev_on_q) begin
        if (has_match) begin
          act_d = ACT_RETRIG;
          tgt_d = match_idx;
        end else if (has_free) begin
          act_d = ACT_LOAD;
          tgt_d = free_idx;
        end else if (has_rel) begin
          act_d = ACT_LOAD;
          tgt_d = rel_idx;
        end else begin
          act_d   = ACT_RETRIG;
          tgt_d   = ptr_q;
          steal_d = 1'b1;
        end
      end else if (has_match) begin
        act_d = ACT_OFF;
        tgt_d = match_idx;
      end
    end

    if ((ctrl_q == C_APPLY) && steal_q) begin
      ptr_d = (ptr_q == IDX_W'(NUM_VOICES - 1)) ? '0 : ptr_q + IDX_W'(1);
    end
  end

  // Handshake, steal pulse and per-voice commands issued in APPLY.
  always_comb begin
    ready_d    = (ctrl_d == C_IDLE);
    stolen_d   = (ctrl_q == C_APPLY) && steal_q;
    cmd_load   = '0;
    cmd_retrig = '0;
    cmd_off    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if ((ctrl_q == C_APPLY) && (tgt_q == IDX_W'(i))) begin
        cmd_load[i]   = (act_q == ACT_LOAD);
        cmd_retrig[i] = (act_q == ACT_RETRIG);
        cmd_off[i]    = (act_q == ACT_OFF);
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(
      .NOTE_W    (NOTE_W),
      .MIN_GATE  (MIN_GATE),
      .RETRIG_LOW(RETRIG_LOW)
    ) u_slot (
      .clk       (Clock),
      .reset     (Reset),
      .running   (Running[g]),
      .cmd_load  (cmd_load[g]),
      .cmd_retrig(cmd_retrig[g]),
      .cmd_off   (cmd_off[g]),
      .load_note (ev_note_q),
      .state     (slot_state[g]),
      .note      (slot_note[g]),
      .gate      (Gate[g]),
      .active    (VoiceActive[g])
    );
    assign VoiceNote[g*NOTE_W +: NOTE_W] = slot_note[g];
  end

  assign EventReady = ready_q;
  assign Stolen     = stolen_q;

endmodule

// File: tb/tb_voice_gate_allocator.sv
// Directed bench for the voice gate allocator: reset, allocation latency,
// minimum gate length, retrigger, stealing, releasing-voice reuse and
// reset while an event is in flight.
module tb_voice_gate_allocator;

  localparam int NV = 4;
  localparam int NW = 7;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          EventValid;
  logic          EventReady;
  logic          EventOn;
  logic [NW-1:0] EventNote;
  logic [NV-1:0] Running;
  logic [NV-1:0] Gate;
  logic [NV*NW-1:0] VoiceNote;
  logic [NV-1:0] VoiceActive;
  logic          Stolen;

  int checks   = 0;
  int failures = 0;

  voice_gate_allocator #(
    .NUM_VOICES(NV),
    .NOTE_W    (NW),
    .MIN_GATE  (16),
    .RETRIG_LOW(2)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .EventValid (EventValid),
    .EventReady (EventReady),
    .EventOn    (EventOn),
    .EventNote  (EventNote),
    .Running    (Running),
    .Gate       (Gate),
    .VoiceNote  (VoiceNote),
    .VoiceActive(VoiceActive),
    .Stolen     (Stolen)
  );

  // Free-running clock.
  always #5 Clock = ~Clock;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [NW-1:0] noteOf(input int idx);
    noteOf = NW'(VoiceNote >> (idx * NW));
  endfunction

  task automatic stepCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for EventReady, then presents one event for one edge.
  task automatic applyStimulus(input logic on, input logic [NW-1:0] note);
    int waited;
    waited = 0;
    while ((EventReady !== 1'b1) && (waited < 20)) begin
      stepCycle();
      waited++;
    end
    checkOutput("ready_wait", {31'd0, EventReady}, 32'd1);
    EventValid = 1'b1;
    EventOn    = on;
    EventNote  = note;
    @(posedge Clock);
    #1;
    EventValid = 1'b0;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    stepCycle();
    Reset = 1'b0;
    stepCycle();
  endtask

  initial begin
    Reset      = 1'b1;
    EventValid = 1'b1;
    EventOn    = 1'b1;
    EventNote  = 7'd5;
    Running    = 4'b0000;

    // Reset held three cycles with an event offered.
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("rst_gate", {28'd0, Gate}, 32'd0);
      checkOutput("rst_ready", {31'd0, EventReady}, 32'd0);
    end
    checkOutput("rst_note", {4'd0, VoiceNote}, 32'd0);
    checkOutput("rst_stolen", {31'd0, Stolen}, 32'd0);
    Reset      = 1'b0;
    EventValid = 1'b0;
    stepCycle();
    checkOutput("ready_after_rst", {31'd0, EventReady}, 32'd1);
    repeat (3) stepCycle();
    checkOutput("no_event_in_rst", {28'd0, VoiceActive}, 32'd0);

    // Note-on 60: visible two edges after acceptance.
    Running = 4'b1111;
    applyStimulus(1'b1, 7'd60);
    stepCycle();
    checkOutput("t1_latency_gate", {28'd0, Gate}, 32'd0);
    stepCycle();
    checkOutput("t1_gate", {28'd0, Gate}, 32'h1);
    checkOutput("t1_note", {25'd0, noteOf(0)}, 32'd60);
    checkOutput("t1_active", {28'd0, VoiceActive}, 32'h1);
    repeat (40) stepCycle();
    applyStimulus(1'b0, 7'd60);
    stepCycle();
    checkOutput("t1_off_pre", {28'd0, Gate}, 32'h1);
    stepCycle();
    checkOutput("t1_off_gate", {28'd0, Gate}, 32'h0);
    checkOutput("t1_releasing", {28'd0, VoiceActive}, 32'h1);
    repeat (10) stepCycle();
    checkOutput("t1_still_rel", {28'd0, VoiceActive}, 32'h1);
    Running = 4'b1110;
    stepCycle();
    checkOutput("t1_freed", {28'd0, VoiceActive}, 32'h0);
    checkOutput("t1_note_kept", {25'd0, noteOf(0)}, 32'd60);
    Running = 4'b1111;

    // Early note-off is held until the gate has been up MIN_GATE counts.
    applyStimulus(1'b1, 7'd62);
    repeat (2) stepCycle();
    checkOutput("t2_gate_on", {28'd0, Gate}, 32'h1);
    applyStimulus(1'b0, 7'd62);
    repeat (15) stepCycle();
    checkOutput("t2_gate_held", {28'd0, Gate}, 32'h1);
    stepCycle();
    checkOutput("t2_gate_fall", {28'd0, Gate}, 32'h0);
    checkOutput("t2_others", {28'd0, VoiceActive}, 32'h1);

    // Retrigger of a held note: two low cycles, no second voice.
    doReset();
    applyStimulus(1'b1, 7'd64);
    repeat (2) stepCycle();
    checkOutput("t3_gate_on", {28'd0, Gate}, 32'h1);
    applyStimulus(1'b1, 7'd64);
    stepCycle();
    checkOutput("t3_pre_retrig", {28'd0, Gate}, 32'h1);
    stepCycle();
    checkOutput("t3_low1", {28'd0, Gate}, 32'h0);
    stepCycle();
    checkOutput("t3_low2", {28'd0, Gate}, 32'h0);
    stepCycle();
    checkOutput("t3_high_again", {28'd0, Gate}, 32'h1);
    checkOutput("t3_one_voice", {28'd0, VoiceActive}, 32'h1);

    // Voice stealing when every voice is held.
    doReset();
    for (int n = 60; n < 64; n++) applyStimulus(1'b1, 7'(n));
    repeat (2) stepCycle();
    checkOutput("t4_all_gate", {28'd0, Gate}, 32'hF);
    checkOutput("t4_notes", {4'd0, VoiceNote}, {4'd0, 7'd63, 7'd62, 7'd61, 7'd60});
    applyStimulus(1'b1, 7'd70);
    stepCycle();
    checkOutput("t4_stolen_early", {31'd0, Stolen}, 32'd0);
    stepCycle();
    checkOutput("t4_stolen", {31'd0, Stolen}, 32'd1);
    checkOutput("t4_gate_steal", {28'd0, Gate}, 32'hE);
    checkOutput("t4_note_steal", {25'd0, noteOf(0)}, 32'd70);
    stepCycle();
    checkOutput("t4_stolen_pulse", {31'd0, Stolen}, 32'd0);
    checkOutput("t4_gate_low2", {28'd0, Gate}, 32'hE);
    stepCycle();
    checkOutput("t4_gate_back", {28'd0, Gate}, 32'hF);
    applyStimulus(1'b1, 7'd71);
    repeat (2) stepCycle();
    checkOutput("t4_steal2_note", {25'd0, noteOf(1)}, 32'd71);
    checkOutput("t4_steal2_gate", {28'd0, Gate}, 32'hD);
    checkOutput("t4_steal2_pulse", {31'd0, Stolen}, 32'd1);

    // Releasing voice reused ahead of stealing.
    doReset();
    for (int n = 60; n < 64; n++) applyStimulus(1'b1, 7'(n));
    repeat (20) stepCycle();
    applyStimulus(1'b0, 7'd62);
    repeat (2) stepCycle();
    checkOutput("t5_rel_gate", {28'd0, Gate}, 32'hB);
    checkOutput("t5_rel_active", {28'd0, VoiceActive}, 32'hF);
    applyStimulus(1'b1, 7'd80);
    repeat (2) stepCycle();
    checkOutput("t5_reuse_gate", {28'd0, Gate}, 32'hF);
    checkOutput("t5_reuse_note", {25'd0, noteOf(2)}, 32'd80);
    checkOutput("t5_no_steal", {31'd0, Stolen}, 32'd0);

    // Reset while the event sits in SEARCH.
    applyStimulus(1'b1, 7'd90);
    Reset = 1'b1;
    stepCycle();
    checkOutput("t6_gate", {28'd0, Gate}, 32'h0);
    checkOutput("t6_active", {28'd0, VoiceActive}, 32'h0);
    checkOutput("t6_note", {4'd0, VoiceNote}, 32'd0);
    checkOutput("t6_ready", {31'd0, EventReady}, 32'd0);
    checkOutput("t6_stolen", {31'd0, Stolen}, 32'd0);
    Reset = 1'b0;
    stepCycle();
    checkOutput("t6_ready_back", {31'd0, EventReady}, 32'd1);
    repeat (3) stepCycle();
    checkOutput("t6_dropped", {28'd0, VoiceActive}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
